// File: rtl/pe_wrapper_mc_if.sv
// Channel bundle between the PE wrapper, its upstream network and the PE core.
// Carries ifmap/filter/ipsum ingress, core-side FIFO heads, opsum return path.
// slave = wrapper side, master = network/core side.
interface pe_wrapper_mc_if #(
  parameter int DATA_SIZE  = 8,
  parameter int IFMAP_NUM  = 1,
  parameter int FILTER_NUM = 4,
  parameter int IPSUM_NUM  = 1,
  parameter int OPSUM_NUM  = 1,
  parameter int ID_BIT     = 4
);
  logic [IFMAP_NUM*DATA_SIZE+ID_BIT:0]  ifmap_in;
  logic                                 ifmap_ready;
  logic [IFMAP_NUM*DATA_SIZE-1:0]       core_ifmap;
  logic                                 core_ifmap_valid;
  logic                                 core_ifmap_ready;

  logic [FILTER_NUM*DATA_SIZE+ID_BIT:0] filter_in;
  logic                                 filter_ready;
  logic [FILTER_NUM*DATA_SIZE-1:0]      core_filter;
  logic                                 core_filter_valid;
  logic                                 core_filter_ready;

  logic [IPSUM_NUM*DATA_SIZE+ID_BIT:0]  ipsum_in;
  logic                                 ipsum_ready;
  logic [IPSUM_NUM*DATA_SIZE-1:0]       core_ipsum;
  logic                                 core_ipsum_valid;
  logic                                 core_ipsum_ready;

  logic [OPSUM_NUM*DATA_SIZE-1:0]       core_opsum;
  logic                                 core_opsum_valid;
  logic                                 core_opsum_ready;
  logic [OPSUM_NUM*DATA_SIZE:0]         opsum_out;
  logic                                 opsum_ready;

  modport slave (
    input  ifmap_in,  output ifmap_ready,  output core_ifmap,  output core_ifmap_valid,  input core_ifmap_ready,
    input  filter_in, output filter_ready, output core_filter, output core_filter_valid, input core_filter_ready,
    input  ipsum_in,  output ipsum_ready,  output core_ipsum,  output core_ipsum_valid,  input core_ipsum_ready,
    input  core_opsum, input core_opsum_valid, output core_opsum_ready,
    output opsum_out,  input opsum_ready
  );

  modport master (
    output ifmap_in,  input ifmap_ready,  input core_ifmap,  input core_ifmap_valid,  output core_ifmap_ready,
    output filter_in, input filter_ready, input core_filter, input core_filter_valid, output core_filter_ready,
    output ipsum_in,  input ipsum_ready,  input core_ipsum,  input core_ipsum_valid,  output core_ipsum_ready,
    output core_opsum, output core_opsum_valid, input core_opsum_ready,
    input  opsum_out,  output opsum_ready
  );
endinterface

// File: rtl/pe_wrapper_mc.sv
// Multicast PE wrapper: tag-filtered input FIFOs, opsum FIFO, config/ID latch, IDLE/RUN/DRAIN FSM.
// Latency: accepted word visible at the core one cycle after the push edge; opsum likewise downstream.
// Backpressure: ready drops only when a matching beat meets a full FIFO; mismatched beats are sunk in RUN.

// Generic synchronous FIFO, head read straight from storage (no pass-through when full).
module pe_wrapper_mc_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  // Pointer and storage update; extra MSB on pointers separates full from empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

// One tagged ingress channel: multicast match, ready generation, FIFO to core.
module pe_wrapper_mc_chan #(
  parameter int DATA_SIZE  = 8,
  parameter int NUM        = 1,
  parameter int ID_BIT     = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          run,
  input  logic [ID_BIT-1:0]             my_id,
  input  logic [NUM*DATA_SIZE+ID_BIT:0] x_in,
  output logic                          x_ready,
  output logic [NUM*DATA_SIZE-1:0]      core_x,
  output logic                          core_x_valid,
  input  logic                          core_x_ready,
  output logic                          empty
);
  localparam int DW = NUM * DATA_SIZE;

  logic              beat_valid;
  logic [ID_BIT-1:0] tag;
  logic [DW-1:0]     data;
  logic              match;
  logic              full;

  assign beat_valid   = x_in[DW+ID_BIT];
  assign tag          = x_in[DW+ID_BIT-1:DW];
  assign data         = x_in[DW-1:0];
  assign match        = (tag == my_id) || (tag == {ID_BIT{1'b1}});
  // Beats not addressed to us are sunk so they never stall the multicast bus.
  assign x_ready      = run && (!match || !full);
  assign core_x_valid = !empty;

  pe_wrapper_mc_fifo #(.W(DW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (beat_valid && match && x_ready),
    .din   (data),
    .pop   (core_x_valid && core_x_ready),
    .dout  (core_x),
    .full  (full),
    .empty (empty)
  );
endmodule

module pe_wrapper_mc #(
  parameter int DATA_SIZE  = 8,
  parameter int IFMAP_NUM  = 1,
  parameter int FILTER_NUM = 4,
  parameter int IPSUM_NUM  = 1,
  parameter int OPSUM_NUM  = 1,
  parameter int ID_BIT     = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int CFG_W      = 39
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              id_set,
  input  logic [ID_BIT-1:0] id_in,
  input  logic              cfg_set,
  input  logic [CFG_W-1:0]  cfg_in,
  pe_wrapper_mc_if.slave    bus,
  output logic [CFG_W-1:0]  core_cfg,
  output logic              core_cfg_valid,
  output logic              core_enable,
  output logic [1:0]        state,
  output logic              done,
  output logic              cfg_err,
  output logic [15:0]       opsum_count
);
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    DRAIN = 2'b10
  } state_t;

  localparam int OW = OPSUM_NUM * DATA_SIZE;

  state_t            st;
  logic [ID_BIT-1:0] my_id;
  logic              cfg_loaded;
  logic              run;
  logic              ifmap_empty;
  logic              filter_empty;
  logic              ipsum_empty;
  logic              opsum_empty;
  logic              opsum_full;
  logic [OW-1:0]     opsum_head;
  logic              opsum_push;
  logic              opsum_pop;
  logic              all_empty;

  assign run         = (st == RUN);
  assign state       = st;
  assign core_enable = (st != IDLE);
  assign all_empty   = ifmap_empty && filter_empty && ipsum_empty && opsum_empty;

  pe_wrapper_mc_chan #(.DATA_SIZE(DATA_SIZE), .NUM(IFMAP_NUM), .ID_BIT(ID_BIT), .FIFO_DEPTH(FIFO_DEPTH)) u_ifmap (
    .clk(clk), .rst(rst), .run(run), .my_id(my_id),
    .x_in(bus.ifmap_in), .x_ready(bus.ifmap_ready),
    .core_x(bus.core_ifmap), .core_x_valid(bus.core_ifmap_valid), .core_x_ready(bus.core_ifmap_ready),
    .empty(ifmap_empty)
  );

  pe_wrapper_mc_chan #(.DATA_SIZE(DATA_SIZE), .NUM(FILTER_NUM), .ID_BIT(ID_BIT), .FIFO_DEPTH(FIFO_DEPTH)) u_filter (
    .clk(clk), .rst(rst), .run(run), .my_id(my_id),
    .x_in(bus.filter_in), .x_ready(bus.filter_ready),
    .core_x(bus.core_filter), .core_x_valid(bus.core_filter_valid), .core_x_ready(bus.core_filter_ready),
    .empty(filter_empty)
  );

  pe_wrapper_mc_chan #(.DATA_SIZE(DATA_SIZE), .NUM(IPSUM_NUM), .ID_BIT(ID_BIT), .FIFO_DEPTH(FIFO_DEPTH)) u_ipsum (
    .clk(clk), .rst(rst), .run(run), .my_id(my_id),
    .x_in(bus.ipsum_in), .x_ready(bus.ipsum_ready),
    .core_x(bus.core_ipsum), .core_x_valid(bus.core_ipsum_valid), .core_x_ready(bus.core_ipsum_ready),
    .empty(ipsum_empty)
  );

  // Opsum path keeps accepting core results while draining so the core can finish.
  assign bus.core_opsum_ready = (st != IDLE) && !opsum_full;
  assign opsum_push           = bus.core_opsum_valid && bus.core_opsum_ready;
  assign opsum_pop            = !opsum_empty && bus.opsum_ready;
  assign bus.opsum_out        = {!opsum_empty, opsum_head};

  pe_wrapper_mc_fifo #(.W(OW), .DEPTH(FIFO_DEPTH)) u_opsum (
    .clk   (clk),
    .rst   (rst),
    .push  (opsum_push),
    .din   (bus.core_opsum),
    .pop   (opsum_pop),
    .dout  (opsum_head),
    .full  (opsum_full),
    .empty (opsum_empty)
  );

  // Control FSM with config/ID latching, error flag, done pulse and delivered-beat counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      st             <= IDLE;
      my_id          <= '0;
      core_cfg       <= '0;
      core_cfg_valid <= 1'b0;
      cfg_loaded     <= 1'b0;
      cfg_err        <= 1'b0;
      done           <= 1'b0;
      opsum_count    <= '0;
    end else begin
      core_cfg_valid <= 1'b0;
      done           <= 1'b0;
      if (opsum_pop && (opsum_count != 16'hFFFF)) opsum_count <= opsum_count + 16'd1;
      case (st)
        IDLE: begin
          if (cfg_set) begin
            core_cfg       <= cfg_in;
            core_cfg_valid <= 1'b1;
            cfg_loaded     <= 1'b1;
          end
          if (id_set) my_id <= id_in;
          if (enable && cfg_loaded) begin
            st          <= RUN;
            opsum_count <= '0;
          end
        end
        RUN: begin
          if (cfg_set || id_set) cfg_err <= 1'b1;
          if (!enable) st <= DRAIN;
        end
        DRAIN: begin
          // enable is deliberately not looked at here: a drain always completes.
          if (cfg_set || id_set) cfg_err <= 1'b1;
          if (all_empty) begin
            st   <= IDLE;
            done <= 1'b1;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pe_wrapper_mc.sv
// Directed bench for pe_wrapper_mc: config/ID load, multicast filtering, FIFO fill/drain,
// opsum backpressure and ordering, DRAIN completion, illegal config and mid-run reset.
// Inputs driven 2 time units after the rising edge; outputs sampled before the next edge.
module tb_pe_wrapper_mc;
  localparam logic [38:0] CFG_A = 39'h5A_1234_5678;
  localparam logic [38:0] CFG_B = 39'h21_8765_4321;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        id_set;
  logic [3:0]  id_in;
  logic        cfg_set;
  logic [38:0] cfg_in;
  logic [38:0] core_cfg;
  logic        core_cfg_valid;
  logic        core_enable;
  logic [1:0]  state;
  logic        done;
  logic        cfg_err;
  logic [15:0] opsum_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pe_wrapper_mc_if bus ();

  pe_wrapper_mc dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .id_set         (id_set),
    .id_in          (id_in),
    .cfg_set        (cfg_set),
    .cfg_in         (cfg_in),
    .bus            (bus),
    .core_cfg       (core_cfg),
    .core_cfg_valid (core_cfg_valid),
    .core_enable    (core_enable),
    .state          (state),
    .done           (done),
    .cfg_err        (cfg_err),
    .opsum_count    (opsum_count)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int k;
    int rcv;
    logic acc;

    rst = 1'b1; enable = 1'b0; id_set = 1'b0; id_in = '0; cfg_set = 1'b0; cfg_in = '0;
    bus.ifmap_in = '0; bus.filter_in = '0; bus.ipsum_in = '0;
    bus.core_ifmap_ready = 1'b0; bus.core_filter_ready = 1'b0; bus.core_ipsum_ready = 1'b0;
    bus.core_opsum = '0; bus.core_opsum_valid = 1'b0; bus.opsum_ready = 1'b0;
    repeat (2) step();

    // Reset state
    chk("rst_state", state, 0);
    chk("rst_core_en", core_enable, 0);
    chk("rst_cfg", core_cfg, 0);
    chk("rst_cfg_vld", core_cfg_valid, 0);
    chk("rst_err", cfg_err, 0);
    chk("rst_done", done, 0);
    chk("rst_cnt", opsum_count, 0);
    chk("rst_ifmap_vld", bus.core_ifmap_valid, 0);
    chk("rst_opsum_vld", bus.opsum_out[8], 0);
    chk("rst_core_opsum_rdy", bus.core_opsum_ready, 0);
    bus.ifmap_in = {1'b1, 4'hF, 8'h00};
    #1 chk("rst_ifmap_rdy", bus.ifmap_ready, 0);
    bus.ifmap_in = '0;
    rst = 1'b0;

    // Config and ID in the same IDLE cycle
    cfg_set = 1'b1; cfg_in = CFG_A; id_set = 1'b1; id_in = 4'h3;
    step();
    cfg_set = 1'b0; id_set = 1'b0;
    chk("cfg_latch", core_cfg, CFG_A);
    chk("cfg_vld_pulse", core_cfg_valid, 1);
    chk("idle_state", state, 0);
    step();
    chk("cfg_vld_low", core_cfg_valid, 0);

    enable = 1'b1;
    step();
    chk("run_state", state, 1);
    chk("run_core_en", core_enable, 1);

    // Matching ifmap beats appear one cycle after accept, in order
    bus.ifmap_in = {1'b1, 4'h3, 8'h11};
    #1 chk("ifmap_rdy", bus.ifmap_ready, 1);
    step();
    bus.ifmap_in = {1'b1, 4'h3, 8'h22};
    #1 chk("ifmap_head0", bus.core_ifmap, 8'h11);
    chk("ifmap_vld0", bus.core_ifmap_valid, 1);
    step();
    bus.ifmap_in = '0;
    chk("ifmap_hold", bus.core_ifmap, 8'h11);
    bus.core_ifmap_ready = 1'b1;
    step();
    chk("ifmap_head1", bus.core_ifmap, 8'h22);
    step();
    chk("ifmap_empty", bus.core_ifmap_valid, 0);
    bus.core_ifmap_ready = 1'b0;

    // Mismatched tag is sunk; broadcast tag is accepted
    bus.ifmap_in = {1'b1, 4'h5, 8'h33};
    #1 chk("mismatch_rdy", bus.ifmap_ready, 1);
    step();
    bus.ifmap_in = '0;
    chk("mismatch_drop", bus.core_ifmap_valid, 0);
    bus.ifmap_in = {1'b1, 4'hF, 8'h44};
    step();
    bus.ifmap_in = '0;
    chk("bcast_head", bus.core_ifmap, 8'h44);
    chk("bcast_vld", bus.core_ifmap_valid, 1);
    bus.core_ifmap_ready = 1'b1;
    step();
    bus.core_ifmap_ready = 1'b0;
    chk("bcast_popped", bus.core_ifmap_valid, 0);

    // Filter FIFO fills at depth 4; mismatched beat still sees ready
    for (int i = 0; i < 5; i++) begin
      bus.filter_in = {1'b1, 4'h3, 32'hA0A0A000 + 32'(i)};
      #1 chk("filt_rdy", bus.filter_ready, (i < 4) ? 1 : 0);
      step();
    end
    bus.filter_in = {1'b1, 4'h6, 32'hDEADBEEF};
    #1 chk("filt_rdy_mismatch_full", bus.filter_ready, 1);
    step();
    bus.filter_in = '0;
    bus.core_filter_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("filt_order", bus.core_filter, 32'hA0A0A000 + 32'(i));
      step();
    end
    chk("filt_empty", bus.core_filter_valid, 0);
    bus.core_filter_ready = 1'b0;

    // Opsum backpressure: 4 buffered, then all 6 delivered in order
    k = 0;
    bus.core_opsum_valid = 1'b1;
    repeat (6) begin
      bus.core_opsum = 8'h50 + 8'(k);
      #1 acc = bus.core_opsum_ready;
      step();
      if (acc) k++;
    end
    chk("opsum_buffered", k, 4);
    bus.core_opsum = 8'h50 + 8'(k);
    #1 chk("opsum_core_rdy_full", bus.core_opsum_ready, 0);
    chk("opsum_out_vld", bus.opsum_out[8], 1);
    chk("opsum_out_head", bus.opsum_out[7:0], 8'h50);
    chk("opsum_cnt_stalled", opsum_count, 0);
    bus.opsum_ready = 1'b1;
    rcv = 0;
    for (int c = 0; c < 20; c++) begin
      bus.core_opsum_valid = (k < 6);
      bus.core_opsum = 8'h50 + 8'(k);
      #1 acc = bus.core_opsum_valid && bus.core_opsum_ready;
      if (bus.opsum_out[8]) begin
        chk("opsum_order", bus.opsum_out[7:0], 8'h50 + 8'(rcv));
        rcv++;
      end
      step();
      if (acc) k++;
    end
    bus.core_opsum_valid = 1'b0;
    bus.opsum_ready = 1'b0;
    chk("opsum_delivered", rcv, 6);
    chk("opsum_count", opsum_count, 6);

    // DRAIN: ingress closed, enable ignored, done after FIFOs empty
    bus.ipsum_in = {1'b1, 4'h3, 8'h61};
    step();
    bus.ipsum_in = {1'b1, 4'h3, 8'h62};
    step();
    bus.ipsum_in = '0;
    enable = 1'b0;
    step();
    chk("drain_state", state, 2);
    chk("drain_core_en", core_enable, 1);
    bus.ipsum_in = {1'b1, 4'h3, 8'h63};
    bus.ifmap_in = {1'b1, 4'h5, 8'h00};
    #1 chk("drain_ipsum_rdy", bus.ipsum_ready, 0);
    chk("drain_ifmap_rdy", bus.ifmap_ready, 0);
    enable = 1'b1;
    step();
    bus.ipsum_in = '0;
    bus.ifmap_in = '0;
    chk("drain_enable_ignored", state, 2);
    chk("drain_ipsum_head0", bus.core_ipsum, 8'h61);
    enable = 1'b0;
    bus.core_ipsum_ready = 1'b1;
    step();
    chk("drain_ipsum_head1", bus.core_ipsum, 8'h62);
    step();
    bus.core_ipsum_ready = 1'b0;
    chk("drain_ipsum_empty", bus.core_ipsum_valid, 0);
    chk("drain_still", state, 2);
    chk("drain_no_done", done, 0);
    step();
    chk("idle_after_drain", state, 0);
    chk("done_pulse", done, 1);
    step();
    chk("done_low", done, 0);
    chk("idle_stays", state, 0);

    // Restart clears the counter; config in RUN is rejected and flagged
    enable = 1'b1;
    step();
    chk("rerun_state", state, 1);
    chk("rerun_cnt_clr", opsum_count, 0);
    cfg_set = 1'b1; cfg_in = CFG_B;
    step();
    cfg_set = 1'b0;
    chk("run_cfg_kept", core_cfg, CFG_A);
    chk("run_cfg_err", cfg_err, 1);
    chk("run_cfg_no_vld", core_cfg_valid, 0);

    // Reset mid-run discards buffered data
    bus.ifmap_in = {1'b1, 4'h3, 8'h99};
    bus.core_opsum_valid = 1'b1; bus.core_opsum = 8'h77;
    step();
    bus.ifmap_in = '0;
    bus.core_opsum_valid = 1'b0;
    chk("pre_rst_ifmap_vld", bus.core_ifmap_valid, 1);
    chk("pre_rst_opsum_vld", bus.opsum_out[8], 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_state", state, 0);
    chk("mid_rst_ifmap_vld", bus.core_ifmap_valid, 0);
    chk("mid_rst_opsum_vld", bus.opsum_out[8], 0);
    chk("mid_rst_err", cfg_err, 0);
    chk("mid_rst_cfg", core_cfg, 0);
    chk("mid_rst_core_en", core_enable, 0);
    step();
    chk("post_rst_no_cfg_idle", state, 0);
    chk("post_rst_ifmap_vld", bus.core_ifmap_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
